// File: rtl/pipeline_execute_stage_n_if.sv
// Handshake and operand bundle for the execute stage.
// The slave modport is the stage itself; the master modport is whoever
// drives decode-side operands and consumes the results.
interface pipeline_execute_stage_n_if #(
  parameter int WIDTH   = 16,
  parameter int CTRL_W  = 22,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [WIDTH-1:0]   in_rm;
  logic [WIDTH-1:0]   in_rn;
  logic [WIDTH-1:0]   in_rd;
  logic [WIDTH-1:0]   in_imm;
  logic [2:0]         in_aluop;
  logic [1:0]         in_shift_mode;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_asel;
  logic               in_bsel;
  logic               out_valid;
  logic               out_ready;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [WIDTH-1:0]   out_rd;
  logic [WIDTH-1:0]   out_result;
  logic [3:0]         out_flags;
  logic               busy;

  modport slave (
    input  flush, in_valid, in_ctrl, in_rm, in_rn, in_rd, in_imm, in_aluop,
           in_shift_mode, in_shamt, in_asel, in_bsel, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_result, out_flags, busy
  );

  modport master (
    output flush, in_valid, in_ctrl, in_rm, in_rn, in_rd, in_imm, in_aluop,
           in_shift_mode, in_shamt, in_asel, in_bsel, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd, out_result, out_flags, busy
  );
endinterface

// File: rtl/pipeline_execute_stage_n.sv
// Execute stage: registers decoded operands, shifts Rm, runs an 8-op ALU
// (multiply is an iterative shift-add), and presents result plus N/Z/C/V
// flags behind a valid/ready handshake on both sides.
module pipeline_execute_stage_n #(
  parameter int WIDTH   = 16,
  parameter int CTRL_W  = 22,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic                       clk,
  input logic                       rst,
  pipeline_execute_stage_n_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  state_t             state_r;
  logic [CTRL_W-1:0]  ctrl_r;
  logic [WIDTH-1:0]   rm_r;
  logic [WIDTH-1:0]   rn_r;
  logic [WIDTH-1:0]   rd_r;
  logic [WIDTH-1:0]   imm_r;
  logic [2:0]         aluop_r;
  logic [1:0]         mode_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic               asel_r;
  logic               bsel_r;
  logic [WIDTH-1:0]   prod_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic               mul_last_r;
  logic               out_valid_r;
  logic               busy_r;

  logic               in_ready_s;
  logic               capture_s;
  logic [WIDTH-1:0]   shifted_s;
  logic [WIDTH-1:0]   a_op_s;
  logic [WIDTH-1:0]   b_op_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   partial_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               c_s;
  logic               v_s;
  logic               n_s;
  logic               z_s;

  assign in_ready_s = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && bus.out_ready);
  // A flush in the same cycle wins over any capture.
  assign capture_s  = bus.in_valid && in_ready_s && !bus.flush;

  // Barrel shifter on the registered Rm; shift amount 0 is a pass-through.
  always_comb begin
    shifted_s = rm_r;
    case (mode_r)
      2'b00:   shifted_s = rm_r;
      2'b01:   shifted_s = rm_r << shamt_r;
      2'b10:   shifted_s = rm_r >> shamt_r;
      2'b11:   shifted_s = WIDTH'($signed(rm_r) >>> shamt_r);
      default: shifted_s = rm_r;
    endcase
  end

  assign a_op_s    = bsel_r ? imm_r : rn_r;
  assign b_op_s    = asel_r ? {WIDTH{1'b0}} : shifted_s;
  assign sum_s     = {1'b0, a_op_s} + {1'b0, b_op_s};
  assign diff_s    = {1'b0, a_op_s} - {1'b0, b_op_s};
  // Multiply walks B from the MSB down, so the accumulator doubles each step.
  assign partial_s = b_op_s[cnt_r] ? a_op_s : {WIDTH{1'b0}};

  // ALU result and carry/overflow from the stage registers.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    c_s       = 1'b0;
    v_s       = 1'b0;
    case (aluop_r)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        c_s       = sum_s[WIDTH];
        v_s       = (a_op_s[WIDTH-1] == b_op_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != a_op_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        c_s       = ~diff_s[WIDTH];
        v_s       = (a_op_s[WIDTH-1] != b_op_s[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != a_op_s[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a_op_s & b_op_s;
      OP_NOT:  alu_res_s = ~b_op_s;
      OP_OR:   alu_res_s = a_op_s | b_op_s;
      OP_XOR:  alu_res_s = a_op_s ^ b_op_s;
      OP_MUL:  alu_res_s = prod_r;
      OP_PASS: alu_res_s = b_op_s;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  assign n_s = alu_res_s[WIDTH-1];
  assign z_s = (alu_res_s == {WIDTH{1'b0}});

  // Result and flags are gated by out_valid so idle, reset and flushed
  // states present all-zero outputs.
  assign bus.out_result = out_valid_r ? alu_res_s : {WIDTH{1'b0}};
  assign bus.out_flags  = out_valid_r ? {n_s, z_s, c_s, v_s} : 4'b0000;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.out_ctrl   = ctrl_r;
  assign bus.out_rd     = rd_r;
  assign bus.in_ready   = in_ready_s;

  // Stage FSM: capture, multiply iterations, retire, flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      ctrl_r      <= {CTRL_W{1'b0}};
      rm_r        <= {WIDTH{1'b0}};
      rn_r        <= {WIDTH{1'b0}};
      rd_r        <= {WIDTH{1'b0}};
      imm_r       <= {WIDTH{1'b0}};
      aluop_r     <= 3'b000;
      mode_r      <= 2'b00;
      shamt_r     <= {SHAMT_W{1'b0}};
      asel_r      <= 1'b0;
      bsel_r      <= 1'b0;
      prod_r      <= {WIDTH{1'b0}};
      cnt_r       <= {SHAMT_W{1'b0}};
      mul_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= ST_EMPTY;
      ctrl_r      <= {CTRL_W{1'b0}};
      rm_r        <= {WIDTH{1'b0}};
      rn_r        <= {WIDTH{1'b0}};
      rd_r        <= {WIDTH{1'b0}};
      imm_r       <= {WIDTH{1'b0}};
      aluop_r     <= 3'b000;
      mode_r      <= 2'b00;
      shamt_r     <= {SHAMT_W{1'b0}};
      asel_r      <= 1'b0;
      bsel_r      <= 1'b0;
      prod_r      <= {WIDTH{1'b0}};
      cnt_r       <= {SHAMT_W{1'b0}};
      mul_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY, ST_FULL: begin
          if (capture_s) begin
            ctrl_r     <= bus.in_ctrl;
            rm_r       <= bus.in_rm;
            rn_r       <= bus.in_rn;
            rd_r       <= bus.in_rd;
            imm_r      <= bus.in_imm;
            aluop_r    <= bus.in_aluop;
            mode_r     <= bus.in_shift_mode;
            shamt_r    <= bus.in_shamt;
            asel_r     <= bus.in_asel;
            bsel_r     <= bus.in_bsel;
            prod_r     <= {WIDTH{1'b0}};
            cnt_r      <= SHAMT_W'(WIDTH - 1);
            mul_last_r <= 1'b0;
            if (bus.in_aluop == OP_MUL) begin
              state_r     <= ST_MUL;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b1;
            end else begin
              state_r     <= ST_FULL;
              out_valid_r <= 1'b1;
              busy_r      <= 1'b0;
            end
          end else if ((state_r == ST_FULL) && bus.out_ready) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_MUL: begin
          // The extra cycle after the last accumulate only publishes the
          // product, keeping the adder out of the handshake path.
          if (mul_last_r) begin
            state_r     <= ST_FULL;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            mul_last_r  <= 1'b0;
          end else begin
            prod_r <= {prod_r[WIDTH-2:0], 1'b0} + partial_s;
            if (cnt_r == {SHAMT_W{1'b0}}) begin
              mul_last_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r - SHAMT_W'(1);
            end
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= {SHAMT_W{1'b0}};
          mul_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_execute_stage_n.sv
// Directed bench for pipeline_execute_stage_n (WIDTH=16).
module tb_pipeline_execute_stage_n;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipeline_execute_stage_n_if #(.WIDTH(16), .CTRL_W(22), .SHAMT_W(4)) bus ();

  pipeline_execute_stage_n #(.WIDTH(16), .CTRL_W(22), .SHAMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] rn;
    logic [15:0] rm;
    logic [15:0] imm;
    logic [2:0]  op;
    logic [1:0]  mode;
    logic [3:0]  sh;
    logic        asel;
    logic        bsel;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_op(input logic [15:0] rn, input logic [15:0] rm,
                          input logic [15:0] imm, input logic [2:0] op,
                          input logic [1:0] mode, input logic [3:0] sh,
                          input logic asel, input logic bsel,
                          input logic [21:0] ctrl, input logic [15:0] rd);
    bus.in_rn         = rn;
    bus.in_rm         = rm;
    bus.in_imm        = imm;
    bus.in_aluop      = op;
    bus.in_shift_mode = mode;
    bus.in_shamt      = sh;
    bus.in_asel       = asel;
    bus.in_bsel       = bsel;
    bus.in_ctrl       = ctrl;
    bus.in_rd         = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive_op(16'h0, 16'h0, 16'h0, 3'b000, 2'b00, 4'h0, 1'b0, 1'b0, 22'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy: got valid=%b busy=%b need 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.out_result !== 16'h0 || bus.out_flags !== 4'h0) begin
      errors++; $display("FAIL reset_result_flags: got %h/%b need 0000/0000", bus.out_result, bus.out_flags);
    end
    checks++;
    if (bus.out_ctrl !== 22'h0 || bus.out_rd !== 16'h0) begin
      errors++; $display("FAIL reset_ctrl_rd: got %h/%h need 0/0", bus.out_ctrl, bus.out_rd);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready);
    end
  endtask

  task automatic test_alu();
    vec_t vecs[13];
    vecs[0]  = '{16'h7FFF, 16'h0001, 16'h0000, 3'b000, 2'b00, 4'd0,  1'b0, 1'b0, 16'h8000, 4'b1001};
    vecs[1]  = '{16'h0000, 16'h1234, 16'h1234, 3'b001, 2'b00, 4'd0,  1'b0, 1'b1, 16'h0000, 4'b0110};
    vecs[2]  = '{16'h0000, 16'h8004, 16'h0000, 3'b111, 2'b11, 4'd2,  1'b0, 1'b0, 16'hE001, 4'b1000};
    vecs[3]  = '{16'h0000, 16'h8004, 16'h0000, 3'b111, 2'b10, 4'd2,  1'b0, 1'b0, 16'h2001, 4'b0000};
    vecs[4]  = '{16'h0000, 16'h00F0, 16'h0000, 3'b011, 2'b01, 4'd4,  1'b0, 1'b0, 16'hF0FF, 4'b1000};
    vecs[5]  = '{16'hFFFF, 16'h0001, 16'h0000, 3'b000, 2'b00, 4'd0,  1'b0, 1'b0, 16'h0000, 4'b0110};
    vecs[6]  = '{16'h0001, 16'h0002, 16'h0000, 3'b001, 2'b00, 4'd0,  1'b0, 1'b0, 16'hFFFF, 4'b1000};
    vecs[7]  = '{16'hA5A5, 16'hFFFF, 16'h0000, 3'b101, 2'b00, 4'd0,  1'b1, 1'b0, 16'hA5A5, 4'b1000};
    vecs[8]  = '{16'hF0F0, 16'h3C3C, 16'h0000, 3'b010, 2'b00, 4'd0,  1'b0, 1'b0, 16'h3030, 4'b0000};
    vecs[9]  = '{16'hFFFF, 16'h00F0, 16'h0F00, 3'b100, 2'b00, 4'd0,  1'b0, 1'b1, 16'h0FF0, 4'b0000};
    vecs[10] = '{16'h0000, 16'h8001, 16'h0000, 3'b111, 2'b11, 4'd1,  1'b0, 1'b0, 16'hC000, 4'b1000};
    vecs[11] = '{16'h0000, 16'h0003, 16'h0000, 3'b111, 2'b01, 4'd15, 1'b0, 1'b0, 16'h8000, 4'b1000};
    vecs[12] = '{16'h8000, 16'h0001, 16'h0000, 3'b001, 2'b00, 4'd0,  1'b0, 1'b0, 16'h7FFF, 4'b0011};
    for (int i = 0; i < 13; i++) begin
      drive_op(vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].op, vecs[i].mode,
               vecs[i].sh, vecs[i].asel, vecs[i].bsel, 22'h2A5A5 ^ 22'(i), 16'hBEEF ^ 16'(i));
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vecs[i].res) begin
        errors++; $display("FAIL alu_result[%0d]: got valid=%b res=%h need 1 %h", i, bus.out_valid, bus.out_result, vecs[i].res);
      end
      checks++;
      if (bus.out_flags !== vecs[i].flg) begin
        errors++; $display("FAIL alu_flags[%0d]: got %b need %b", i, bus.out_flags, vecs[i].flg);
      end
      checks++;
      if (bus.out_ctrl !== (22'h2A5A5 ^ 22'(i)) || bus.out_rd !== (16'hBEEF ^ 16'(i))) begin
        errors++; $display("FAIL alu_ctrl_rd[%0d]: got %h/%h need %h/%h", i, bus.out_ctrl, bus.out_rd, 22'h2A5A5 ^ 22'(i), 16'hBEEF ^ 16'(i));
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0) begin
        errors++; $display("FAIL alu_retire[%0d]: got valid=%b res=%h need 0 0000", i, bus.out_valid, bus.out_result);
      end
    end
  endtask

  task automatic test_mul();
    int cycles;
    int viol;
    drive_op(16'h0123, 16'h0010, 16'h0, 3'b110, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00111, 16'h0001);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    // second op held valid right behind the multiply
    drive_op(16'h0001, 16'h0002, 16'h0, 3'b000, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00222, 16'h0002);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mul_start: got busy=%b in_ready=%b valid=%b need 1 0 0", bus.busy, bus.in_ready, bus.out_valid);
    end
    cycles = 0; viol = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.out_valid !== 1'b1 && (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)) viol++;
    end
    checks++;
    if (cycles !== 17) begin
      errors++; $display("FAIL mul_latency: got %0d cycles need 17", cycles);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL mul_busy_hold: got %0d bad cycles need 0", viol);
    end
    checks++;
    if (bus.out_result !== 16'h1230 || bus.out_flags !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mul_result: got %h/%b busy=%b need 1230/0000 0", bus.out_result, bus.out_flags, bus.busy);
    end
    checks++;
    if (bus.out_ctrl !== 22'h00111) begin
      errors++; $display("FAIL mul_ctrl: got %h need 00111", bus.out_ctrl);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0003 || bus.out_ctrl !== 22'h00222) begin
      errors++; $display("FAIL mul_next_op: got valid=%b res=%h ctrl=%h need 1 0003 00222", bus.out_valid, bus.out_result, bus.out_ctrl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bad;
    drive_op(16'h1111, 16'h2222, 16'h0, 3'b000, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00AAA, 16'h0AAA);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    drive_op(16'h0005, 16'h0003, 16'h0, 3'b001, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00BBB, 16'h0BBB);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3333 || bus.out_flags !== 4'b0000 ||
          bus.out_ctrl !== 22'h00AAA || bus.out_rd !== 16'h0AAA || bus.in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stall_hold: got %0d unstable cycles need 0", bad);
    end
    checks++;
    if (bus.out_result !== 16'h3333 || bus.out_ctrl !== 22'h00AAA) begin
      errors++; $display("FAIL stall_end: got %h/%h need 3333/00AAA", bus.out_result, bus.out_ctrl);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stream_in_ready: got %b need 1", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0002 || bus.out_flags !== 4'b0010) begin
      errors++; $display("FAIL stream_op2: got valid=%b %h/%b need 1 0002/0010", bus.out_valid, bus.out_result, bus.out_flags);
    end
    drive_op(16'h0004, 16'h0004, 16'h0, 3'b010, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00CCC, 16'h0CCC);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0004 || bus.out_ctrl !== 22'h00CCC) begin
      errors++; $display("FAIL stream_op3: got valid=%b %h ctrl=%h need 1 0004 00CCC", bus.out_valid, bus.out_result, bus.out_ctrl);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got valid=%b need 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    int cycles;
    drive_op(16'h0123, 16'h0010, 16'h0, 3'b110, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00DDD, 16'h0DDD);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_mul: got valid=%b busy=%b in_ready=%b need 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
    end
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_no_valid: got %0d valid cycles need 0", seen);
    end
    drive_op(16'h0007, 16'h0001, 16'h0, 3'b000, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00EEE, 16'h0EEE);
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 22'h0) begin
      errors++; $display("FAIL flush_drop_capture: got valid=%b ctrl=%h need 0 0", bus.out_valid, bus.out_ctrl);
    end
    // a fresh multiply after the abort must start from a clean accumulator
    drive_op(16'h0003, 16'h0005, 16'h0, 3'b110, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00F0F, 16'h0F0F);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (cycles !== 17 || bus.out_result !== 16'h000F) begin
      errors++; $display("FAIL flush_then_mul: got %0d cycles res=%h need 17 000F", cycles, bus.out_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drive_op(16'h0123, 16'h0010, 16'h0, 3'b110, 2'b00, 4'd0, 1'b0, 1'b0, 22'h01234, 16'h1234);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_mul_ctrl: got valid=%b busy=%b in_ready=%b need 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
    end
    checks++;
    if (bus.out_result !== 16'h0 || bus.out_flags !== 4'h0 || bus.out_ctrl !== 22'h0 || bus.out_rd !== 16'h0) begin
      errors++; $display("FAIL rst_mid_mul_data: got %h/%b/%h/%h need all 0", bus.out_result, bus.out_flags, bus.out_ctrl, bus.out_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_no_stale_valid: got %0d valid cycles need 0", seen);
    end
    drive_op(16'h0002, 16'h0003, 16'h0, 3'b000, 2'b00, 4'd0, 1'b0, 1'b0, 22'h00555, 16'h0555);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0005) begin
      errors++; $display("FAIL rst_recover: got valid=%b res=%h need 1 0005", bus.out_valid, bus.out_result);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alu();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
